// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor (BHT + BTB) with an EX-stage resolver.
// Ports: clk/rst; IFPC -> PredTaken/PredTarget (IF lookup);
//   IFIDStall/IFIDFlush/IDEXFlush steer the shadow pipeline;
//   EXIsBranch/EXIsJump/EXTaken/EXTarget resolve the EX instruction
//   into Nexttype/RedirectPC; BrCount/MissCount are statistics.
module branch_predict_unit #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IFPC,
    output logic             PredTaken,
    output logic [31:0]      PredTarget,
    input  logic             IFIDStall,
    input  logic             IFIDFlush,
    input  logic             IDEXFlush,
    input  logic             EXIsBranch,
    input  logic             EXIsJump,
    input  logic             EXTaken,
    input  logic [31:0]      EXTarget,
    output logic [1:0]       Nexttype,
    output logic [31:0]      RedirectPC,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] NT_PC4   = 2'b00;
    localparam logic [1:0] NT_BR_OK = 2'b01;
    localparam logic [1:0] NT_BR_NG = 2'b10;
    localparam logic [1:0] NT_JUMP  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred;
    } shadow_t;

    logic [1:0]       cnt_q [N];
    logic [1:0]       cnt_d [N];
    logic             vld_q [N];
    logic             vld_d [N];
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];
    logic [31:0]      tgt_q [N];
    logic [31:0]      tgt_d [N];

    shadow_t ifid_q, ifid_d;
    shadow_t idex_q, idex_d;

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic [31:0]      ex_pc4;
    logic             mispredict;
    logic             update;

    // IF lookup reads the registered table, so an entry written on
    // this edge is only seen by fetches in the following cycle.
    assign if_idx     = IFPC[IDX_W+1:2];
    assign if_tag     = IFPC[31:IDX_W+2];
    assign PredTaken  = vld_q[if_idx] && (tag_q[if_idx] == if_tag)
                        && cnt_q[if_idx][1];
    assign PredTarget = tgt_q[if_idx];

    assign ex_idx = idex_q.pc[IDX_W+1:2];
    assign ex_tag = idex_q.pc[31:IDX_W+2];
    assign ex_pc4 = idex_q.pc + 32'd4;

    assign BrCount   = br_cnt_q;
    assign MissCount = miss_cnt_q;

    // Resolution; jump wins over branch when both are flagged.
    always_comb begin
        Nexttype   = NT_PC4;
        RedirectPC = ex_pc4;
        mispredict = 1'b0;
        update     = 1'b0;
        if (idex_q.valid) begin
            unique case (1'b1)
                EXIsJump: begin
                    Nexttype = NT_JUMP;
                end
                (EXIsBranch && !EXIsJump): begin
                    update = 1'b1;
                    if (EXTaken == idex_q.pred) begin
                        Nexttype = NT_BR_OK;
                    end else begin
                        Nexttype   = NT_BR_NG;
                        mispredict = 1'b1;
                        RedirectPC = EXTaken ? EXTarget : ex_pc4;
                    end
                end
                default: begin
                    Nexttype = NT_PC4;
                end
            endcase
        end
    end

    // Shadow pipeline; flush beats stall in IFID.
    always_comb begin
        ifid_d = ifid_q;
        if (IFIDFlush) begin
            ifid_d.valid = 1'b0;
        end else if (!IFIDStall) begin
            ifid_d.valid = 1'b1;
            ifid_d.pc    = IFPC;
            ifid_d.pred  = PredTaken;
        end
        idex_d = ifid_q;
        if (IDEXFlush) begin
            idex_d.valid = 1'b0;
        end
    end

    // Table and statistics update.
    always_comb begin
        cnt_d      = cnt_q;
        vld_d      = vld_q;
        tag_d      = tag_q;
        tgt_d      = tgt_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (update) begin
            if (EXTaken) begin
                if (cnt_q[ex_idx] != 2'b11) begin
                    cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
                end
                vld_d[ex_idx] = 1'b1;
                tag_d[ex_idx] = ex_tag;
                tgt_d[ex_idx] = EXTarget;
            end else if (cnt_q[ex_idx] != 2'b00) begin
                cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
            end
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (mispredict && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= 2'b01;
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            ifid_q     <= '0;
            idex_q     <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
                vld_q[i] <= vld_d[i];
                tag_q[i] <= tag_d[i];
                tgt_q[i] <= tgt_d[i];
            end
            ifid_q     <= ifid_d;
            idex_q     <= idex_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; EX expectations are queued
// at fetch time and popped when the instruction occupies EX.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IFPC;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        IFIDStall, IFIDFlush, IDEXFlush;
    logic        EXIsBranch, EXIsJump, EXTaken;
    logic [31:0] EXTarget;
    logic [1:0]  Nexttype;
    logic [31:0] RedirectPC;
    logic [1:0]  BrCount, MissCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [1:0]  nt;
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];

    branch_predict_unit #(.IDX_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .IFPC(IFPC),
        .PredTaken(PredTaken), .PredTarget(PredTarget),
        .IFIDStall(IFIDStall), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .EXIsBranch(EXIsBranch),
        .EXIsJump(EXIsJump), .EXTaken(EXTaken),
        .EXTarget(EXTarget), .Nexttype(Nexttype),
        .RedirectPC(RedirectPC), .BrCount(BrCount),
        .MissCount(MissCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [31:0] pc, input logic br,
                       input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic st,
                       input logic f1, input logic f2);
        IFPC = pc; EXIsBranch = br; EXIsJump = jmp; EXTaken = tk;
        EXTarget = tgt; IFIDStall = st; IFIDFlush = f1; IDEXFlush = f2;
    endtask

    task automatic idle(input logic [31:0] pc);
        drv(pc, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic push(input string tag, input logic [1:0] nt,
                        input logic [31:0] rd);
        exp_t e;
        e.tag = tag; e.nt = nt; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic pop_ex();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed 0 expected >0");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_nt"}, 32'(Nexttype), 32'(e.nt));
            chk({e.tag, "_rd"}, RedirectPC, e.rd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle(32'h40);
        #2;
        chk("rst_pt", 32'(PredTaken), 0);
        chk("rst_ptgt", PredTarget, 0);
        chk("rst_nt", 32'(Nexttype), 0);
        chk("rst_rd", RedirectPC, 32'h4);
        chk("rst_br", 32'(BrCount), 0);
        chk("rst_miss", 32'(MissCount), 0);
        @(negedge clk);
        rst = 1'b0;

        // A: fetch branch 0x40, cold table
        idle(32'h40); push("br40_first", 2'b10, 32'h80); #1;
        chk("a_pt", 32'(PredTaken), 0);
        chk("a_nt", 32'(Nexttype), 0);
        step();
        // B
        idle(32'h100); #1;
        chk("b_nt", 32'(Nexttype), 0);
        step();
        // C: 0x40 in EX, taken; same-cycle lookup sees old entry
        drv(32'h40, 1, 0, 1, 32'h80, 0, 1, 1); #1;
        pop_ex();
        chk("c_pt_old", 32'(PredTaken), 0);
        step();
        // D: entry visible; fetch 0x40 predicted taken
        idle(32'h40); push("br40_miss_nt", 2'b10, 32'h44); #1;
        chk("d_pt", 32'(PredTaken), 1);
        chk("d_ptgt", PredTarget, 32'h80);
        chk("d_br", 32'(BrCount), 1);
        chk("d_miss", 32'(MissCount), 1);
        chk("d_nt", 32'(Nexttype), 0);
        step();
        // E: load stall with 0x40 in IFID; aliasing tag misses
        drv(32'h100, 0, 0, 0, 32'h0, 1, 0, 1); #1;
        chk("e_pt_alias", 32'(PredTaken), 0);
        chk("e_nt", 32'(Nexttype), 0);
        step();
        // E2: bubble in EX
        idle(32'h100); #1;
        chk("e2_nt_bubble", 32'(Nexttype), 0);
        step();
        // F: 0x40 resolves not taken vs pred 1
        drv(32'h304, 1, 0, 0, 32'h80, 0, 1, 1); #1;
        pop_ex();
        step();
        // G: counter 2->1, BTB still valid
        idle(32'h40); push("br40_ok", 2'b01, 32'h44); #1;
        chk("g_pt", 32'(PredTaken), 0);
        chk("g_ptgt", PredTarget, 32'h80);
        chk("g_br", 32'(BrCount), 2);
        chk("g_miss", 32'(MissCount), 2);
        chk("g_nt", 32'(Nexttype), 0);
        step();
        // H
        idle(32'h104); push("alu104", 2'b00, 32'h108); #1;
        chk("h_nt", 32'(Nexttype), 0);
        step();
        // I: 0x40 not taken, predicted not taken
        drv(32'h50, 1, 0, 0, 32'h80, 0, 0, 0);
        push("jmp50", 2'b11, 32'h54); #1;
        pop_ex();
        step();
        // J
        idle(32'h60); push("alu60", 2'b00, 32'h64); #1;
        pop_ex();
        chk("j_br", 32'(BrCount), 3);
        chk("j_miss", 32'(MissCount), 2);
        step();
        // K: jump with branch flag also set
        drv(32'h50, 1, 1, 1, 32'h200, 0, 0, 0);
        push("alu50", 2'b00, 32'h54); #1;
        pop_ex();
        chk("k_pt", 32'(PredTaken), 0);
        step();
        // L: no update from jump
        idle(32'hFFFF_FFFC); push("br_wrap", 2'b01, 32'h0); #1;
        pop_ex();
        chk("l_pt", 32'(PredTaken), 0);
        chk("l_br", 32'(BrCount), 3);
        chk("l_miss", 32'(MissCount), 2);
        step();
        // M: lookup at 0x50 untouched by the jump
        idle(32'h50); push("br50_taken", 2'b10, 32'h200); #1;
        pop_ex();
        chk("m_pt_nojmpupd", 32'(PredTaken), 0);
        step();
        // N: wrap branch at 0xFFFFFFFC, pc+4 wraps to 0
        drv(32'h40, 1, 0, 0, 32'h0, 0, 0, 0); #1;
        pop_ex();
        step();
        // O: branch in EX, then async reset
        drv(32'h40, 1, 0, 1, 32'h200, 0, 0, 0); #1;
        pop_ex();
        chk("o_br_sat", 32'(BrCount), 3);
        chk("o_miss", 32'(MissCount), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_nt", 32'(Nexttype), 0);
        chk("ar_rd", RedirectPC, 32'h4);
        chk("ar_br", 32'(BrCount), 0);
        chk("ar_miss", 32'(MissCount), 0);
        chk("ar_ptgt", PredTarget, 0);
        step();
        chk("ar_hold_nt", 32'(Nexttype), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(32'h40); #1;
        chk("post_pt", 32'(PredTaken), 0);
        chk("post_ptgt", PredTarget, 0);
        chk("post_nt", 32'(Nexttype), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic branch predictor and EX-stage branch resolver for the 5-stage pipelined CPU. It predicts taken/not-taken plus target for the PC in IF, carries each prediction alongside the IF/ID and ID/EX pipeline registers, and resolves it in EX. From that resolution it drives the `Nexttype` code and the corrective PC consumed by the hazard detection unit and the PC mux. It obeys that unit's `IFIDStall`/`IFIDFlush`/`IDEXFlush` outputs so its shadow state stays aligned with the pipeline.

## Interface
Parameters:
- `IDX_W`, default 4: BHT/BTB index width; the table holds 2^IDX_W entries, indexed by `pc[IDX_W+1:2]`, with tag `pc[31:IDX_W+2]`.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `IFPC`  in  32: PC currently being fetched.
- `PredTaken`  out  1: IF-stage prediction (combinational).
- `PredTarget`  out  32: predicted target, meaningful when `PredTaken`=1.
- `IFIDStall`, `IFIDFlush`, `IDEXFlush`  in  1 each: hazard-unit controls, applied to the shadow registers.
- `EXIsBranch`  in  1: the instruction in EX is a conditional branch.
- `EXIsJump`  in  1: the instruction in EX is a J or JAL.
- `EXTaken`  in  1: actual branch outcome from the EX comparator.
- `EXTarget`  in  32: computed branch target.
- `Nexttype`  out  2: 00 `PCPlus4`, 01 `Branch` (prediction correct), 10 `BranchWrong`, 11 `Jump`.
- `RedirectPC`  out  32: corrective PC; valid when `Nexttype`=10.
- `BrCount`  out  CNT_W: number of resolved branches.
- `MissCount`  out  CNT_W: number of mispredicted branches.

## Operation
Prediction table. Each entry holds a 2-bit saturating counter, a BTB valid bit, a tag, and a 32-bit target.
- Lookup at IF: `PredTaken` = valid && tag match && counter[1]. `PredTarget` = the entry's target.

Shadow pipeline. Stage IFID holds {valid, pc, pred}; stage IDEX holds the same fields.
- IFID: `IFIDFlush` clears valid. Otherwise `IFIDStall` holds the stage. Otherwise it loads {1, `IFPC`, `PredTaken`}. Flush beats stall.
- IDEX: `IDEXFlush` clears valid (bubble). Otherwise it loads from IFID.
- Load stall (`IFIDStall`=1 and `IDEXFlush`=1): IFID holds and IDEX becomes a bubble.

Resolution. Combinational from the IDEX stage and the EX inputs, evaluated only when IDEX valid=1; otherwise `Nexttype`=00.
- `EXIsJump` → 11. Jump has priority over branch if both inputs are high.
- `EXIsBranch` with `EXTaken` == stored pred → 01.
- `EXIsBranch` with a mismatch → 10. `RedirectPC` = `EXTaken` ? `EXTarget` : IDEX pc+4.
- Any other instruction → 00.
- `RedirectPC` = IDEX pc+4 whenever `Nexttype`≠10.

Update. On the rising edge with IDEX valid and `EXIsBranch`=1, the entry indexed by IDEX pc is updated:
- Counter: increment if taken, decrement if not, saturating at 3 and 0.
- If taken: write tag and target, and set valid.
- A not-taken branch does not clear BTB valid.
- `BrCount` increments. `MissCount` increments on a mismatch. Both saturate at all-ones.

## Timing
- Reset values:
  - all counters 2'b01 (weakly not taken); all BTB valid 0; tags and targets 0;
  - both shadow stages valid=0, pc=0, pred=0;
  - `BrCount`=`MissCount`=0;
  - outputs therefore `PredTaken`=0, `PredTarget`=0, `Nexttype`=00, `RedirectPC`=32'h4.
- Latency:
  - prediction is zero-cycle (combinational on `IFPC`);
  - a prediction reaches EX two edges after fetch, with no stalls;
  - `Nexttype` is valid in the same cycle the branch occupies EX.
- A table update becomes visible to IF lookups on the cycle after the resolving edge. A same-cycle lookup of the index being updated returns the old contents.
- Reset asserted mid-operation clears all state immediately, with no clock edge needed; outputs take their reset values while `rst`=1.
- Address arithmetic: pc+4 is 32-bit with wrap (32'hFFFFFFFC+4 = 0). No carry is kept.

## Test plan
- Reset, then `IFPC`=0x40 → `PredTaken`=0. `Nexttype`=00 for two cycles (shadow stages empty).
- Branch at 0x40 taken to 0x80, first occurrence → in EX, `Nexttype`=10, `RedirectPC`=0x80. Next cycle the lookup at 0x40 gives `PredTaken`=1, `PredTarget`=0x80; `MissCount`=1, `BrCount`=1.
- Same branch, now predicted taken, resolves not taken → `Nexttype`=10, `RedirectPC`=0x44. Counter goes from 2 to 1. A subsequent not-taken resolution gives `Nexttype`=01.
- Load stall: hold `IFIDStall`=1 and `IDEXFlush`=1 for one cycle while a branch sits in IFID → IDEX is a bubble (`Nexttype`=00). The branch reaches EX one cycle later with its original pred bit.
- Jump in EX with `EXIsBranch`=1 also asserted → `Nexttype`=11, with no table update and no change to the counters.
- Assert `rst` asynchronously while a branch is in EX → `Nexttype` drops to 00 immediately. The table returns to counter 01 with BTB valid 0. Repeat 0x40 → `PredTaken`=0.
